// File: rtl/aes_iter_encrypt.sv
// rtl/aes_iter_encrypt.sv - iterative AES-128/256 block encryptor, one round per clock
// Accepts one plaintext/key pair over a valid/ready handshake, runs NR rounds with the
// round keys expanded on the fly, then holds the ciphertext until the sink takes it.
// Ports:
//   clk, rst                  single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready         block source handshake (plain_text, key)
//   plain_text[127:0]         plaintext, FIPS-197 byte order (byte0 = [127:120])
//   key[KEY_BITS-1:0]         cipher key, same byte order
//   out_valid/out_ready       ciphertext sink handshake
//   cipher[127:0]             registered ciphertext
//   busy                      a block is being processed or held
module aes_iter_encrypt #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        plain_text,
    input  logic [KEY_BITS-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        cipher,
    output logic                busy
);
    localparam int KW = KEY_BITS;
    localparam int NR = (KEY_BITS == 256) ? 14 : 10;
    localparam logic [3:0] NR_L = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_encrypt: KEY_BITS must be 128 or 256");
    end

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
    state_t state, state_next;

    logic [127:0] st;
    logic [KW-1:0] kw;     // sliding key window: the most recent KEY_BITS of the schedule
    logic [3:0]   rnd;
    logic [7:0]   rcon;
    logic         accept;

    // ---------------- round datapath ----------------
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];
    logic [127:0] sr_flat, mc_flat;

    always_comb begin
        sr_flat = '0;
        mc_flat = '0;
        for (int i = 0; i < 16; i++) sb[i] = sbox(st[127 - 8 * i -: 8]);
        // ShiftRows: row r of column c takes row r of column (c + r) mod 4
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4 * c + r] = sb[4 * ((c + r) % 4) + r];
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            sr_flat[127 - 8 * i -: 8] = sr[i];
            mc_flat[127 - 8 * i -: 8] = mc[i];
        end
    end

    // ---------------- key schedule ----------------
    // Each round derives four new words from the oldest four words in the window
    // (kw_hi) and the newest word (last_w). AES-256 alternates between the
    // RotWord+Rcon step (even rounds) and the SubWord-only step (odd rounds);
    // round 1 of AES-256 simply uses the second half of the cipher key.
    logic         rot_mode;
    logic [127:0] kw_hi;
    logic [31:0]  last_w, rot_w, sub_w, f_w;
    logic [31:0]  nw [4];
    logic [127:0] new_words, round_key, next_st;

    always_comb begin
        rot_mode  = (KEY_BITS == 128) || !rnd[0];
        kw_hi     = kw[KW-1 -: 128];
        last_w    = kw[31:0];
        rot_w     = rot_mode ? {last_w[23:0], last_w[31:24]} : last_w;
        sub_w     = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
        f_w       = sub_w ^ (rot_mode ? {rcon, 24'h0} : 32'h0);
        nw[0]     = kw_hi[127:96] ^ f_w;
        nw[1]     = kw_hi[95:64]  ^ nw[0];
        nw[2]     = kw_hi[63:32]  ^ nw[1];
        nw[3]     = kw_hi[31:0]   ^ nw[2];
        new_words = {nw[0], nw[1], nw[2], nw[3]};
        round_key = (KEY_BITS == 256 && rnd == 4'd1) ? kw[127:0] : new_words;
        next_st   = ((rnd == NR_L) ? sr_flat : mc_flat) ^ round_key;
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_next = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (rnd == NR_L) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= '0;
            kw     <= '0;
            rnd    <= '0;
            rcon   <= 8'h01;
            cipher <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                st   <= plain_text ^ key[KEY_BITS-1 -: 128];
                kw   <= key;
                rnd  <= 4'd1;
                rcon <= 8'h01;
            end
        end else if (state == ROUND) begin
            st  <= next_st;
            rnd <= rnd + 4'd1;
            if (rot_mode) rcon <= xtime(rcon);
            if (!(KEY_BITS == 256 && rnd == 4'd1)) kw <= KW'({kw, new_words});
            if (rnd == NR_L) cipher <= next_st;
        end
    end
endmodule

// File: tb/tb_aes_iter_encrypt.sv
// tb/tb_aes_iter_encrypt.sv - self-checking bench for aes_iter_encrypt (AES-128 and AES-256)
module tb_aes_iter_encrypt;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_pt, a_key, a_cipher;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_pt, b_cipher;
    logic [255:0] b_key;

    aes_iter_encrypt #(.KEY_BITS(128)) dut128 (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .plain_text(a_pt), .key(a_key), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .cipher(a_cipher), .busy(a_busy));

    aes_iter_encrypt #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .plain_text(b_pt), .key(b_key), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .cipher(b_cipher), .busy(b_busy));

    int passed = 0;
    int total  = 0;
    logic [7:0] sbox_m [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, want);
    endtask

    // ---------------- reference model (FIPS-197, word-array key expansion) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // key is left-aligned in 256 bits; nk = 4 or 8 words
    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [255:0] k, input int nk);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i/4][31 - 8 * (i % 4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
            for (int i = 0; i < 16; i++) s[i] = t[4 * ((i / 4 + i % 4) % 4) + i % 4];
            if (r != nr) begin
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++)
                        t[4*c+row] = gmul(8'h02, s[4*c+row]) ^ gmul(8'h03, s[4*c+(row+1)%4])
                                   ^ s[4*c+(row+2)%4] ^ s[4*c+(row+3)%4];
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8 * (i % 4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- DUT access helpers ----------------
    function automatic logic ov(input int sel);
        return (sel != 0) ? b_out_valid : a_out_valid;
    endfunction
    function automatic logic ir(input int sel);
        return (sel != 0) ? b_in_ready : a_in_ready;
    endfunction
    function automatic logic bz(input int sel);
        return (sel != 0) ? b_busy : a_busy;
    endfunction
    function automatic logic [127:0] ct(input int sel);
        return (sel != 0) ? b_cipher : a_cipher;
    endfunction
    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [127:0] pt, input logic [255:0] k);
        if (sel == 0) begin a_in_valid = v; a_pt = pt; a_key = k[255:128]; end
        else          begin b_in_valid = v; b_pt = pt; b_key = k; end
    endtask

    task automatic set_or(input int sel, input logic v);
        if (sel == 0) a_out_ready = v;
        else          b_out_ready = v;
    endtask

    // one full block: accept, latency, result, handshake
    task automatic run_block(input int sel, input logic [127:0] pt, input logic [255:0] k,
                             input logic [127:0] want, input string name);
        int lat;
        int nr;
        nr = (sel != 0) ? 14 : 10;
        check({name, "_in_ready_idle"}, 128'(ir(sel)), 128'd1);
        set_in(sel, 1'b1, pt, k);
        @(posedge clk); #1;
        set_in(sel, 1'b0, rnd128(), {rnd128(), rnd128()});   // inputs may change after accept
        check({name, "_busy"}, 128'(bz(sel)), 128'd1);
        lat = 0;
        while (!ov(sel) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 128'(lat), 128'(nr));
        check({name, "_cipher"}, ct(sel), want);
        set_or(sel, 1'b1);
        @(posedge clk); #1;
        set_or(sel, 1'b0);
        check({name, "_out_valid_after_hs"}, 128'(ov(sel)), 128'd0);
        check({name, "_in_ready_after_hs"}, 128'(ir(sel)), 128'd1);
    endtask

    typedef struct {
        int           sel;
        logic [127:0] pt;
        logic [255:0] key;
        logic [127:0] want;
    } vec_t;

    localparam logic [127:0] T1_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] T1_KEY = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] T1_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] T2_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] T2_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] T2_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] T3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] T3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [3];
        logic [7:0]   inv, b;
        logic [127:0] pt, want;
        logic [255:0] k;
        int           sel, cnt, acc, nout, nrise, cyc;
        logic         acc_now, hs_now, prev_ov;
        logic [127:0] got;
        logic [127:0] outs [2];
        int           hs_cyc [2];
        int           rise_cyc [2];

        // S-box from its definition: GF(2^8) inverse followed by the affine map
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end

        vecs[0] = '{0, T1_PT, T1_KEY, T1_CT};
        vecs[1] = '{0, T2_PT, T2_KEY, T2_CT};
        vecs[2] = '{1, T2_PT, T3_KEY, T3_CT};

        rst = 1'b1;
        set_in(0, 1'b0, '0, '0);
        set_in(1, 1'b0, '0, '0);
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready128", 128'(a_in_ready), 128'd0);
        check("rst_out_valid128", 128'(a_out_valid), 128'd0);
        check("rst_busy128", 128'(a_busy), 128'd0);
        check("rst_cipher128", a_cipher, 128'd0);
        check("rst_cipher256", b_cipher, 128'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready256", 128'(b_in_ready), 128'd1);
        @(posedge clk); #1;

        // known-answer vectors
        for (int i = 0; i < 3; i++)
            run_block(vecs[i].sel, vecs[i].pt, vecs[i].key, vecs[i].want, $sformatf("kat%0d", i));

        // random blocks against the model
        for (int n = 0; n < 12; n++) begin
            sel = n % 2;
            pt  = rnd128();
            k   = (sel != 0) ? {rnd128(), rnd128()} : {rnd128(), 128'h0};
            want = ref_enc(pt, k, (sel != 0) ? 8 : 4);
            run_block(sel, pt, k, want, $sformatf("rand%0d", n));
        end

        // back-pressure: output held, new input ignored while held
        set_in(0, 1'b1, T1_PT, T1_KEY);
        @(posedge clk); #1;
        set_in(0, 1'b1, T2_PT, T2_KEY);
        cnt = 0;
        while (!a_out_valid && cnt < 40) begin @(posedge clk); #1; cnt++; end
        check("bp_latency", 128'(cnt), 128'd10);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid_held", 128'(a_out_valid), 128'd1);
            check("bp_cipher_stable", a_cipher, T1_CT);
            check("bp_in_ready_low", 128'(a_in_ready), 128'd0);
        end
        a_out_ready = 1'b1;
        a_in_valid  = 1'b0;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        check("bp_out_valid_done", 128'(a_out_valid), 128'd0);
        check("bp_in_ready_idle", 128'(a_in_ready), 128'd1);
        check("bp_busy_idle", 128'(a_busy), 128'd0);
        check("bp_cipher_kept", a_cipher, T1_CT);

        // mid-block reset during round 5 of T2
        set_in(0, 1'b1, T2_PT, T2_KEY);
        @(posedge clk); #1;
        set_in(0, 1'b0, '0, '0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_forces_in_ready", 128'(b_in_ready), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 128'(a_busy), 128'd0);
        check("midrst_cipher", a_cipher, 128'd0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (a_out_valid) cnt++;
            @(posedge clk); #1;
        end
        check("midrst_no_out_valid", 128'(cnt), 128'd0);
        run_block(0, T1_PT, T1_KEY, T1_CT, "after_rst");

        // back-to-back with out_ready held high
        a_out_ready = 1'b1;
        set_in(0, 1'b1, T1_PT, T1_KEY);
        acc = 0; nout = 0; nrise = 0; cyc = 0; prev_ov = 1'b0;
        outs[0] = '0; outs[1] = '0;
        hs_cyc[0] = 0; hs_cyc[1] = 0; rise_cyc[0] = 0; rise_cyc[1] = 0;
        while (nout < 2 && cyc < 80) begin
            acc_now = a_in_valid && a_in_ready;
            hs_now  = a_out_valid && a_out_ready;
            got     = a_cipher;
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                acc++;
                if (acc == 1) set_in(0, 1'b1, T2_PT, T2_KEY);
                else          set_in(0, 1'b0, '0, '0);
            end
            if (hs_now && nout < 2) begin
                outs[nout]   = got;
                hs_cyc[nout] = cyc;
                nout++;
            end
            if (a_out_valid && !prev_ov && nrise < 2) begin
                rise_cyc[nrise] = cyc;
                nrise++;
            end
            prev_ov = a_out_valid;
        end
        a_out_ready = 1'b0;
        set_in(0, 1'b0, '0, '0);
        check("b2b_outputs", 128'(nout), 128'd2);
        check("b2b_accepts", 128'(acc), 128'd2);
        check("b2b_first", outs[0], T1_CT);
        check("b2b_second", outs[1], T2_CT);
        check("b2b_first_latency", 128'(rise_cyc[0] - 1), 128'd10);
        check("b2b_gap", 128'(rise_cyc[1] - hs_cyc[0]), 128'd11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
